// File: rtl/clock_pkg.sv
// Shared BCD clock types and moduli for the time-of-day counter and the
// downstream 7-segment decoders.
package clock_pkg;

   typedef logic [3:0] bcd_t;

   localparam int SEC_MOD  = 60;
   localparam int MIN_MOD  = 60;
   localparam int HOUR_MOD = 24;

   localparam bcd_t BCD_ZERO = 4'd0;
   localparam bcd_t BCD_NINE = 4'd9;

endpackage : clock_pkg

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter wrapping at MODULUS-1; wrap_o flags the increment
// that rolls the pair back to 00 so the caller can carry into the next field.
module bcd2_counter
   import clock_pkg::*;
#(
   parameter int MODULUS = 60
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic clr_i,
   output bcd_t hi_o,
   output bcd_t lo_o,
   output logic wrap_o
);

   localparam bcd_t HI_MAX = bcd_t'((MODULUS - 1) / 10);
   localparam bcd_t LO_MAX = bcd_t'((MODULUS - 1) % 10);

   bcd_t hi_q, hi_d;
   bcd_t lo_q, lo_d;
   logic at_max_s;

   assign at_max_s = (hi_q == HI_MAX) && (lo_q == LO_MAX);
   assign wrap_o   = inc_i && at_max_s;

   // Next-state: clear dominates increment; units roll 9->0 into tens.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (clr_i) begin
         hi_d = BCD_ZERO;
         lo_d = BCD_ZERO;
      end else if (inc_i) begin
         if (at_max_s) begin
            hi_d = BCD_ZERO;
            lo_d = BCD_ZERO;
         end else if (lo_q == BCD_NINE) begin
            hi_d = hi_q + 4'd1;
            lo_d = BCD_ZERO;
         end else begin
            hi_d = hi_q;
            lo_d = lo_q + 4'd1;
         end
      end else begin
         hi_d = hi_q;
         lo_d = lo_q;
      end
   end

   // Digit registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hi_q <= BCD_ZERO;
         lo_q <= BCD_ZERO;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule : bcd2_counter

// File: rtl/time_bcd_counter.sv
// 24-hour HH:MM:SS BCD time-of-day counter with 1 Hz prescaler, run/stop
// control and minute/hour set pulses that take priority over the tick.
module time_bcd_counter
   import clock_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       run_i,
   input  logic       inc_min_i,
   input  logic       inc_hour_i,
   output logic [3:0] hour_hi_o,
   output logic [3:0] hour_lo_o,
   output logic [3:0] min_hi_o,
   output logic [3:0] min_lo_o,
   output logic [3:0] sec_hi_o,
   output logic [3:0] sec_lo_o,
   output logic       sec_tick_o,
   output logic       day_tick_o
);

   localparam int              DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             sec_tick_q, sec_tick_d;
   logic             day_tick_q, day_tick_d;

   logic tick_s;
   logic adv_s;
   logic sec_inc_s, min_inc_s, hour_inc_s;
   logic sec_wrap_s, min_wrap_s, hour_wrap_s;

   assign tick_s = run_i && (div_cnt_q == DIV_LAST);
   // A set pulse in a tick cycle swallows that second's advance.
   assign adv_s  = tick_s && !inc_min_i && !inc_hour_i;

   assign sec_inc_s  = adv_s;
   assign min_inc_s  = inc_min_i  || (adv_s && sec_wrap_s);
   assign hour_inc_s = inc_hour_i || (adv_s && min_wrap_s);

   // Prescaler next-state and registered tick pulses.
   always_comb begin
      div_cnt_d  = div_cnt_q;
      sec_tick_d = adv_s;
      day_tick_d = adv_s && hour_wrap_s;
      if (inc_min_i) begin
         div_cnt_d = '0;
      end else if (tick_s) begin
         div_cnt_d = '0;
      end else if (run_i) begin
         div_cnt_d = div_cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
      end else begin
         div_cnt_d = div_cnt_q;
      end
   end

   // Prescaler and pulse registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_cnt_q  <= '0;
         sec_tick_q <= 1'b0;
         day_tick_q <= 1'b0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         sec_tick_q <= sec_tick_d;
         day_tick_q <= day_tick_d;
      end
   end

   bcd2_counter #(.MODULUS(SEC_MOD)) u_sec (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (sec_inc_s),
      .clr_i  (inc_min_i),
      .hi_o   (sec_hi_o),
      .lo_o   (sec_lo_o),
      .wrap_o (sec_wrap_s)
   );

   bcd2_counter #(.MODULUS(MIN_MOD)) u_min (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (min_inc_s),
      .clr_i  (1'b0),
      .hi_o   (min_hi_o),
      .lo_o   (min_lo_o),
      .wrap_o (min_wrap_s)
   );

   bcd2_counter #(.MODULUS(HOUR_MOD)) u_hour (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (hour_inc_s),
      .clr_i  (1'b0),
      .hi_o   (hour_hi_o),
      .lo_o   (hour_lo_o),
      .wrap_o (hour_wrap_s)
   );

   assign sec_tick_o = sec_tick_q;
   assign day_tick_o = day_tick_q;

endmodule : time_bcd_counter

// File: tb/tb_time_bcd_counter.sv
// Directed bench for time_bcd_counter with TICK_DIV=4: stimulus pushes
// hand-computed expectations into a queue, a negedge monitor pops and compares.
module tb_time_bcd_counter;

   logic       clk = 1'b0;
   logic       rst_i = 1'b0;
   logic       run_i = 1'b0;
   logic       inc_min_i = 1'b0;
   logic       inc_hour_i = 1'b0;
   logic [3:0] hour_hi_o, hour_lo_o, min_hi_o, min_lo_o, sec_hi_o, sec_lo_o;
   logic       sec_tick_o, day_tick_o;

   typedef struct packed {
      logic [3:0] hh;
      logic [3:0] hl;
      logic [3:0] mh;
      logic [3:0] ml;
      logic [3:0] sh;
      logic [3:0] sl;
      logic       st;
      logic       dt;
   } obs_t;

   obs_t  exp_q[$];
   string name_q[$];
   int    total = 0;
   int    bad = 0;

   always #5 clk = ~clk;

   time_bcd_counter #(.TICK_DIV(4)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .run_i      (run_i),
      .inc_min_i  (inc_min_i),
      .inc_hour_i (inc_hour_i),
      .hour_hi_o  (hour_hi_o),
      .hour_lo_o  (hour_lo_o),
      .min_hi_o   (min_hi_o),
      .min_lo_o   (min_lo_o),
      .sec_hi_o   (sec_hi_o),
      .sec_lo_o   (sec_lo_o),
      .sec_tick_o (sec_tick_o),
      .day_tick_o (day_tick_o)
   );

   // Monitor: compare registered outputs against queued expectations.
   always @(negedge clk) begin
      obs_t  act;
      obs_t  e;
      string nm;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         act = '{hour_hi_o, hour_lo_o, min_hi_o, min_lo_o, sec_hi_o, sec_lo_o,
                 sec_tick_o, day_tick_o};
         total++;
         if (act !== e) begin
            bad++;
            $display("FAIL %s: got %h%h:%h%h:%h%h st=%b dt=%b, want %h%h:%h%h:%h%h st=%b dt=%b",
                     nm, act.hh, act.hl, act.mh, act.ml, act.sh, act.sl, act.st, act.dt,
                     e.hh, e.hl, e.mh, e.ml, e.sh, e.sl, e.st, e.dt);
         end
      end
   end

   task automatic cyc(input logic rst, input logic run, input logic im, input logic ih);
      rst_i      = rst;
      run_i      = run;
      inc_min_i  = im;
      inc_hour_i = ih;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_t(input string nm, input int hh, input int hl, input int mh,
                           input int ml, input int sh, input int sl, input int st,
                           input int dt);
      obs_t e;
      e = '{hh[3:0], hl[3:0], mh[3:0], ml[3:0], sh[3:0], sl[3:0], st[0], dt[0]};
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   initial begin
      @(posedge clk);
      #1;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      expect_t("reset", 0, 0, 0, 0, 0, 0, 0, 0);

      // 12 running cycles: ticks on every 4th cycle
      for (int k = 1; k <= 12; k++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
         expect_t("run12", 0, 0, 0, 0, 0, k / 4, (k % 4 == 0) ? 1 : 0, 0);
      end

      // mid-count reset overriding all inputs, then prescaler restarts from 0
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      expect_t("midreset", 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
         expect_t("postreset", 0, 0, 0, 0, 0, k / 4, (k == 4) ? 1 : 0, 0);
      end

      // preload 23:59:58 with held set pulses and 58 seconds of ticks
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 23; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      expect_t("set23h", 2, 3, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 59; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      expect_t("set59m", 2, 3, 5, 9, 0, 0, 0, 0);
      for (int k = 0; k < 232; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      expect_t("at235958", 2, 3, 5, 9, 5, 8, 1, 0);
      for (int k = 1; k <= 4; k++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
         if (k < 4) expect_t("to235959", 2, 3, 5, 9, 5, 8, 0, 0);
         else       expect_t("to235959", 2, 3, 5, 9, 5, 9, 1, 0);
      end
      for (int k = 1; k <= 5; k++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
         if (k < 4)       expect_t("rollover", 2, 3, 5, 9, 5, 9, 0, 0);
         else if (k == 4) expect_t("rollover", 0, 0, 0, 0, 0, 0, 1, 1);
         else             expect_t("rollover", 0, 0, 0, 0, 0, 0, 0, 0);
      end

      // 00:59:30, inc_min coincident with a tick: no hour carry, no sec tick
      for (int k = 0; k < 59; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      expect_t("set0059", 0, 0, 5, 9, 0, 0, 0, 0);
      for (int k = 0; k < 120; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      expect_t("at005930", 0, 0, 5, 9, 3, 0, 1, 0);
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      expect_t("pretick", 0, 0, 5, 9, 3, 0, 0, 0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      expect_t("minwrap", 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
         if (k >= 3) expect_t("divclr", 0, 0, 0, 0, 0, k / 4, (k == 4) ? 1 : 0, 0);
      end

      // 23:xx hour set wraps to 00 without day tick
      for (int k = 0; k < 23; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      expect_t("set23", 2, 3, 0, 0, 0, 1, 0, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      expect_t("hourwrap", 0, 0, 0, 0, 0, 1, 0, 0);

      // stopped: frozen, but hour set still works; prescaler resumes from 0
      for (int k = 0; k < 20; k++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
         expect_t("frozen", 0, 0, 0, 0, 0, 1, 0, 0);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      expect_t("stophour", 0, 1, 0, 0, 0, 1, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
         if (k == 3) expect_t("resume", 0, 1, 0, 0, 0, 1, 0, 0);
         if (k == 4) expect_t("resume", 0, 1, 0, 0, 0, 2, 1, 0);
      end

      // inc_hour coincident with a tick at 10:20:05
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 20; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      expect_t("set1020", 1, 0, 2, 0, 0, 0, 0, 0);
      for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      expect_t("at102005", 1, 0, 2, 0, 0, 5, 1, 0);
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      expect_t("hourtick", 1, 1, 2, 0, 0, 5, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
         if (k == 3) expect_t("nexttick", 1, 1, 2, 0, 0, 5, 0, 0);
         if (k == 4) expect_t("nexttick", 1, 1, 2, 0, 0, 6, 1, 0);
      end

      // both set pulses together: both increment, seconds clear
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      expect_t("bothset", 1, 2, 2, 1, 0, 0, 0, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      expect_t("idle", 1, 2, 2, 1, 0, 0, 0, 0);

      @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_time_bcd_counter

// File: doc/time_bcd_counter.md
Name: time_bcd_counter

Overview:
- 24-hour time-of-day counter producing six BCD digits (HH:MM:SS).
- Sits directly upstream of the per-digit BCD-to-7-segment decoders; each digit output drives one decoder's 4-bit BCD input.
- Contains an internal prescaler that turns the system clock into a 1 Hz advance.
- Provides minute/hour set pulses for user adjustment, plus a run/stop control.

Parameters:
- TICK_DIV, 50_000_000, system clock cycles per second tick. Legal range is >= 1; a value of 1 gives one tick per cycle (simulation).
- DIV_W, $clog2(TICK_DIV) with a minimum of 1, width of the prescaler counter. Derived; not overridden.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset. Synchronous, active-high.
- run_i  input  1  1 = time advances; 0 = prescaler and time hold.
- inc_min_i  input  1  single-cycle pulse (already debounced): increment minutes.
- inc_hour_i  input  1  single-cycle pulse (already debounced): increment hours.
- hour_hi_o  output  4  hours tens digit, range 0..2.
- hour_lo_o  output  4  hours units digit, range 0..9 (0..3 when hour_hi_o=2).
- min_hi_o  output  4  minutes tens digit, range 0..5.
- min_lo_o  output  4  minutes units digit, range 0..9.
- sec_hi_o  output  4  seconds tens digit, range 0..5.
- sec_lo_o  output  4  seconds units digit, range 0..9.
- sec_tick_o  output  1  one-cycle pulse in the cycle the seconds advance (used for colon blink).
- day_tick_o  output  1  one-cycle pulse when time rolls over from 23:59:59 to 00:00:00.

Behaviour:
- One clock; reset is synchronous and active-high. All state updates occur on the rising edge of clk_i.
- Reset (rst_i=1 at an edge):
  - all digits become 0 (00:00:00);
  - prescaler becomes 0;
  - sec_tick_o and day_tick_o become 0.
  - Reset overrides every other input and takes effect mid-operation with no residue.
- Prescaler:
  - When run_i=1, div_cnt increments each cycle.
  - When div_cnt=TICK_DIV-1, it wraps to 0 and an internal tick asserts for that cycle.
  - When run_i=0, div_cnt holds and no tick is generated.
- Time advance on tick. With no set pulse in the same cycle:
  - Seconds increment by one. sec_lo goes 9->0 with a carry to sec_hi; sec_hi goes 5->0 with a carry to minutes.
  - Minutes use the same rules, with the carry going to hours.
  - Hours: hour_lo goes 9->0 with a carry to hour_hi; 23 goes to 00 and raises day_tick.
- All outputs are registered. Digit registers drive the outputs directly.
- sec_tick_o and day_tick_o are registered pulses, high in the cycle after the tick edge. They align with the updated digit values (both become visible together).
- Latency: a tick arising at edge N (div_cnt wrapping) updates the digits and pulses at edge N, visible in the following cycle.
- Set pulses (honoured regardless of run_i):
  - inc_min_i: minutes increment mod 60 with no carry into hours (59->00 leaves hours unchanged). Seconds clear to 00 and div_cnt clears to 0.
  - inc_hour_i: hours increment mod 24 (23->00). day_tick_o does not assert. Minutes, seconds and prescaler are unaffected; the prescaler keeps counting if run_i=1.
  - Both pulses in the same cycle: both increments apply, and the seconds/prescaler clear applies.
- Simultaneous set pulse and tick:
  - The set action has priority and the time advance for that cycle is dropped.
  - sec_tick_o and day_tick_o stay 0.
  - The prescaler still wraps, or clears if inc_min_i is asserted.
- Held pulses: a pulse input held high for k cycles produces k increments. Edge detection is upstream.
- Digit values stay in legal ranges at all times. Illegal BCD states are unreachable from reset; no recovery logic is required.

Decomposition:
- Shared package clock_pkg:
  - typedef bcd_t (logic [3:0]);
  - constants SEC_MOD=60, MIN_MOD=60, HOUR_MOD=24.
  - Lives alongside the decoder's BCD type usage.
- One sub-module, bcd2_counter: a two-digit BCD counter with parameter MODULUS (60 or 24).
  - Inputs: inc, clr.
  - Outputs: hi, lo, wrap (combinational, high when inc is asserted at MODULUS-1).
  - Instantiated three times (seconds, minutes, hours).
  - Set logic, priority and the prescaler live in the top level.

Test Plan:
- Reset, then TICK_DIV=4, run_i=1 for 12 cycles -> sec_lo_o=3 and sec_tick_o pulsed exactly 3 times, 4 cycles apart. Assert rst_i for one cycle mid-count -> all digits 0 and div_cnt 0 on the next cycle.
- Preload to 23:59:58 via set pulses (23 inc_hour_i, 59 inc_min_i), then 58 seconds of ticks; run 2 more ticks -> 23:59:59 then 00:00:00, with day_tick_o high for exactly one cycle coincident with the 00:00:00 digits.
- At 00:59:30, pulse inc_min_i -> 00:00:00 (no hour carry), div_cnt=0, no sec_tick_o that cycle.
- At 23:xx, pulse inc_hour_i -> 00:xx with day_tick_o remaining 0.
- With run_i=0 for 20 cycles -> digits and div_cnt frozen. inc_hour_i still increments hours.
- Align inc_hour_i with a tick cycle at 10:20:05 -> 11:20:05 (seconds do not advance) and sec_tick_o=0. Next tick -> 11:20:06.
